// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirects, one-entry stall buffer.
// Optional IF_ALIGN_CHECK_EN adds a sticky fetch_err for misaligned targets.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   jr,
    input  logic [31:0]            jr_target,
    input  logic                   jump,
    input  logic [25:0]            jump_index,
    input  logic [31:0]            jump_base_pc,
    input  logic                   branch_taken,
    input  logic [15:0]            branch_offset,
    input  logic [31:0]            branch_base_pc,
    if_fetch_unit_if.master        imem,
    output logic                   if_valid,
    output logic [31:0]            if_instr,
    output logic [31:0]            if_pc
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic                   fetch_err
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_KILL = 2'd3;

    logic [1:0]  state_reg;
    logic [31:0] pc_reg;
    logic [31:0] kill_addr_reg;
    logic        pending_reg;
    logic [31:0] hold_instr_reg;
    logic [31:0] hold_pc_reg;
    logic        if_valid_reg;
    logic [31:0] if_instr_reg;
    logic [31:0] if_pc_reg;

    logic        redirect;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] raw_target;
    logic [31:0] redirect_target;
    logic        mem_req;
    logic        ack;
    logic [31:0] pc_plus4;

    assign jump_target   = ((jump_base_pc + 32'd4) & 32'hF000_0000) | {4'b0000, jump_index, 2'b00};
    assign branch_target = branch_base_pc + 32'd4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign redirect      = jr | jump | branch_taken;
    assign raw_target    = jr ? jr_target : (jump ? jump_target : branch_target);
    assign redirect_target = raw_target & 32'hFFFF_FFFC;
    assign pc_plus4      = pc_reg + 32'd4;

    // A raised request stays up until acked; stall only suppresses a fresh one.
    assign mem_req   = (state_reg == ST_KILL) || ((state_reg == ST_REQ) && (pending_reg || !stall));
    assign ack       = imem.ack & mem_req;
    assign imem.req  = mem_req;
    assign imem.addr = (state_reg == ST_KILL) ? kill_addr_reg : pc_reg;

    assign if_valid = if_valid_reg;
    assign if_instr = if_instr_reg;
    assign if_pc    = if_pc_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            kill_addr_reg  <= '0;
            pending_reg    <= 1'b0;
            hold_instr_reg <= '0;
            hold_pc_reg    <= '0;
            if_valid_reg   <= 1'b0;
            if_instr_reg   <= '0;
            if_pc_reg      <= '0;
        end else begin
            if (redirect) begin
                pc_reg       <= redirect_target;
                if_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: state_reg <= ST_REQ;
                ST_REQ: begin
                    if (redirect) begin
                        // An unacked request cannot be withdrawn: drain it in KILL.
                        pending_reg   <= 1'b0;
                        kill_addr_reg <= pc_reg;
                        state_reg     <= (mem_req && !ack) ? ST_KILL : ST_REQ;
                    end else if (ack) begin
                        pending_reg <= 1'b0;
                        pc_reg      <= pc_plus4;
                        if (stall) begin
                            hold_instr_reg <= imem.rdata;
                            hold_pc_reg    <= pc_reg;
                            state_reg      <= ST_HOLD;
                        end else begin
                            if_instr_reg <= imem.rdata;
                            if_pc_reg    <= pc_reg;
                            if_valid_reg <= 1'b1;
                        end
                    end else begin
                        pending_reg <= mem_req;
                        if (!stall) begin
                            if_valid_reg <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        state_reg <= ST_REQ;
                    end else if (!stall) begin
                        if_instr_reg <= hold_instr_reg;
                        if_pc_reg    <= hold_pc_reg;
                        if_valid_reg <= 1'b1;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_KILL: begin
                    if (ack) begin
                        state_reg <= ST_REQ;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    logic fetch_err_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_err_reg <= 1'b0;
        end else if (redirect && (raw_target[1:0] != 2'b00)) begin
            fetch_err_reg <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_reg;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected fetch PCs are queued as stimulus
// is applied and popped whenever ID accepts an instruction (if_valid & !stall).
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jr;
    logic [31:0] jr_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] jump_base_pc;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] branch_base_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef IF_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    bit          mem_manual = 1'b0;
    int          mem_wait = 0;
    logic        man_ack = 1'b0;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .jr             (jr),
        .jr_target      (jr_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .jump_base_pc   (jump_base_pc),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .branch_base_pc (branch_base_pc),
        .imem           (bus),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .fetch_err      (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after mem_wait idle cycles, or follows man_ack.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.ack   = 1'b0;
        bus.rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_manual) begin
                bus.ack   = man_ack;
                bus.rdata = mem_word(bus.addr);
                wcnt = 0;
            end else if (!rst || !bus.req) begin
                bus.ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= mem_wait) begin
                bus.ack   = 1'b1;
                bus.rdata = mem_word(bus.addr);
                wcnt = 0;
            end else begin
                bus.ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Consumer side of the scoreboard, sampled just before the rising edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid_pc", if_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("if_pc", if_pc, e);
                    check_eq("if_instr", if_instr, mem_word(e));
                    $display("accepted pc=%h instr=%h", if_pc, if_instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input int wait_cyc, input bit manual);
        @(negedge clk);
        stall = 1'b1; rst = 1'b0;
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        man_ack = 1'b0; mem_manual = manual; mem_wait = wait_cyc;
        @(negedge clk);
        @(negedge clk);
        #2;
        check_eq("rst_req", {31'b0, bus.req}, 32'd0);
        check_eq("rst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_if_instr", if_instr, 32'd0);
`ifdef IF_ALIGN_CHECK_EN
        check_eq("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
`endif
        exp_q.delete();
    endtask

    task automatic release_rst(input logic st);
        @(negedge clk);
        rst = 1'b1;
        stall = st;
        #2;
        check_eq("idle_req", {31'b0, bus.req}, 32'd0);
    endtask

    task automatic wait_addr(input logic [31:0] a, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (bus.req === 1'b1 && bus.addr === a) return;
        end
        check_eq("wait_addr_timeout", bus.addr, a);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                stall = 1'b1;
                break;
            end
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b1;
        jr = 1'b0; jr_target = '0;
        jump = 1'b0; jump_index = '0; jump_base_pc = '0;
        branch_taken = 1'b0; branch_offset = '0; branch_base_pc = '0;

        // Zero-wait memory: one instruction per cycle from RESET_PC.
        do_reset(0, 1'b0);
        release_rst(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            check_eq("seq_req", {31'b0, bus.req}, 32'd1);
            check_eq("seq_addr", bus.addr, 32'(4 * i));
            if (i == 0) check_eq("seq_first_valid", {31'b0, if_valid}, 32'd0);
        end
        drain(5);

        // Two wait states, stall during the ack of pc 8 -> HOLD, emitted once.
        do_reset(2, 1'b0);
        release_rst(1'b0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        wait_addr(32'h8, 40);
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            if (bus.req === 1'b0) break;
        end
        check_eq("hold_entered", {31'b0, bus.req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check_eq("hold_req", {31'b0, bus.req}, 32'd0);
            check_eq("hold_valid", {31'b0, if_valid}, 32'd0);
        end
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        #2;
        check_eq("hold_out_valid", {31'b0, if_valid}, 32'd1);
        check_eq("hold_out_pc", if_pc, 32'h8);
        check_eq("hold_next_addr", bus.addr, 32'hC);
        drain(20);

        // Jump with request outstanding -> KILL, then redirect inside KILL.
        do_reset(0, 1'b1);
        release_rst(1'b0);
        @(negedge clk);
        #2;
        check_eq("kill_first_addr", bus.addr, 32'h0);
        @(negedge clk);
        jump = 1'b1; jump_base_pc = 32'h0040_0010; jump_index = 26'h0000100;
        @(negedge clk);
        jump = 1'b0;
        #2;
        check_eq("kill_req", {31'b0, bus.req}, 32'd1);
        check_eq("kill_old_addr", bus.addr, 32'h0);
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        #2;
        check_eq("kill_valid", {31'b0, if_valid}, 32'd0);
        check_eq("jump_target_addr", bus.addr, 32'h0000_0400);
        exp_q.push_back(32'h400);
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        #2;
        check_eq("after_jump_addr", bus.addr, 32'h404);
        @(negedge clk);
        jr = 1'b1; jr_target = 32'h800;
        @(negedge clk);
        jr_target = 32'h900;
        #2;
        check_eq("kill2_addr", bus.addr, 32'h404);
        @(negedge clk);
        jr = 1'b0;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        #2;
        check_eq("kill2_valid", {31'b0, if_valid}, 32'd0);
        check_eq("kill2_newest_target", bus.addr, 32'h900);
        exp_q.push_back(32'h900);
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        drain(5);

        // Branch with simultaneous ack; then jr and jump together.
        do_reset(0, 1'b0);
        release_rst(1'b0);
        @(negedge clk);
        branch_taken = 1'b1; branch_base_pc = 32'h100; branch_offset = 16'hFFFE;
        #2;
        check_eq("br_pre_addr", bus.addr, 32'h0);
        @(negedge clk);
        branch_taken = 1'b0;
        jr = 1'b1; jr_target = 32'h3000;
        jump = 1'b1; jump_base_pc = 32'h0; jump_index = 26'h3FF_FFFF;
        #2;
        check_eq("br_valid", {31'b0, if_valid}, 32'd0);
        check_eq("br_target_addr", bus.addr, 32'h0000_00FC);
        @(negedge clk);
        jr = 1'b0; jump = 1'b0;
        #2;
        check_eq("jr_priority_addr", bus.addr, 32'h3000);
        exp_q.push_back(32'h3000);
        drain(5);

        // Reset while a request is outstanding, late ack afterwards.
        do_reset(0, 1'b1);
        release_rst(1'b0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        man_ack = 1'b0;
        #2;
        check_eq("pre_reset_addr", bus.addr, 32'h8);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        man_ack = 1'b1;
        #2;
        check_eq("mid_rst_valid", {31'b0, if_valid}, 32'd0);
        check_eq("mid_rst_if_pc", if_pc, 32'd0);
        check_eq("mid_rst_if_instr", if_instr, 32'd0);
        check_eq("mid_rst_req", {31'b0, bus.req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_eq("late_ack_idle_req", {31'b0, bus.req}, 32'd0);
        @(negedge clk);
        man_ack = 1'b0;
        #2;
        check_eq("post_rst_req", {31'b0, bus.req}, 32'd1);
        check_eq("post_rst_addr", bus.addr, 32'h0);
        check_eq("post_rst_valid", {31'b0, if_valid}, 32'd0);
        drain(3);

        // Misaligned jr target is forced to a word address.
        do_reset(0, 1'b0);
        release_rst(1'b1);
        @(negedge clk);
        jr = 1'b1; jr_target = 32'h0000_1002;
        @(negedge clk);
        jr = 1'b0; stall = 1'b0;
        #2;
        check_eq("align_addr", bus.addr, 32'h0000_1000);
        check_eq("align_req", {31'b0, bus.req}, 32'd1);
`ifdef IF_ALIGN_CHECK_EN
        check_eq("fetch_err_set", {31'b0, fetch_err}, 32'd1);
`endif
        exp_q.push_back(32'h1000);
        drain(5);
        repeat (3) @(negedge clk);
        #2;
`ifdef IF_ALIGN_CHECK_EN
        check_eq("fetch_err_sticky", {31'b0, fetch_err}, 32'd1);
`endif
        do_reset(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset, word-aligned.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-low reset; sampled only at posedge clk.
REQ-004 stall  in  1  ID cannot accept an instruction this cycle.
REQ-005 jr, jr_target  in  1, 32  register jump; target used verbatim.
REQ-006 jump, jump_index, jump_base_pc  in  1, 26, 32  J-type taken; index and PC of the jump instruction.
REQ-007 branch_taken, branch_offset, branch_base_pc  in  1, 16, 32  taken branch; signed word offset and PC of the branch instruction.
REQ-008 imem_req, imem_addr  out  1, 32  instruction-memory request and word address.
REQ-009 imem_ack, imem_rdata  in  1, 32  memory completes the request; data valid in the ack cycle.
REQ-010 if_valid, if_instr, if_pc  out  1, 32, 32  IF/ID payload; if_pc is the fetch address.
REQ-011 fetch_err  out  1  sticky misaligned-target flag; present only under the configuration macro.

Function
REQ-012 redirect = jr | jump | branch_taken; priority jr > jump > branch.
REQ-013 Targets: jr = jr_target; jump = {(jump_base_pc+4)[31:28], jump_index, 2'b00}; branch = branch_base_pc + 4 + (sign-extended branch_offset << 2); all modulo 2^32.
REQ-014 States: IDLE, REQ, HOLD, KILL; IDLE lasts one cycle after reset, then REQ.
REQ-015 REQ: imem_req = 1, imem_addr = pc; both stable until imem_ack is seen.
REQ-016 REQ, ack, no stall, no redirect: {if_instr, if_pc, if_valid} <= {imem_rdata, pc, 1}; pc <= pc+4; stay in REQ (one instruction per cycle with zero-wait memory).
REQ-017 REQ, ack while stall = 1: data and pc go to a one-entry hold register; pc <= pc+4; go to HOLD; outputs unchanged.
REQ-018 REQ, no ack: if stall = 0, if_valid <= 0; if stall = 1, outputs held.
REQ-019 HOLD: imem_req = 0; when stall drops, the hold entry moves to the outputs with if_valid = 1, then go to REQ.
REQ-020 Stall with no outstanding request (REQ not yet issued) deasserts imem_req; a request once raised is never withdrawn before ack.
REQ-021 Redirect in any state: if_valid <= 0, hold entry discarded, pc <= target, regardless of stall.
REQ-022 Redirect with request outstanding and no ack in the same cycle: go to KILL; imem_req stays high at the old address; the ack data is discarded; then go to REQ at the target.
REQ-023 Redirect in the same cycle as ack: data discarded; next state REQ at the target.
REQ-024 Redirect in KILL: pc updated to the newest target; remain in KILL until ack.
REQ-025 if_valid never rises for a fetch address issued before the most recent redirect.

Reset
REQ-026 rst = 0 at posedge: state IDLE, pc = RESET_PC, imem_req = 0, if_valid = 0, if_instr = 0, if_pc = 0, hold cleared, fetch_err = 0.
REQ-027 Reset during an outstanding request abandons it; a late ack after reset (state IDLE) is ignored.

Configuration
REQ-028 Macro IF_ALIGN_CHECK_EN defined: fetch_err sets when a selected redirect target has bits [1:0] != 0, stays set until reset; pc takes the target with bits [1:0] forced to 0.
REQ-029 Macro IF_ALIGN_CHECK_EN undefined: no fetch_err port; target bits [1:0] forced to 0 silently.

Verification
REQ-030 Reset release, imem_ack tied 1, stall 0 -> addresses 0,4,8,... on consecutive cycles; if_valid high from cycle 3 with if_pc 0,4,8.
REQ-031 Ack with 2 wait cycles, stall 1 during ack at pc 8 -> HOLD; stall released 3 cycles later -> if_pc = 8 emitted once, next request at 12.
REQ-032 jump_base_pc 0x0040_0010, jump_index 0x0000100, request outstanding -> KILL, old data dropped, next imem_addr = 0x0000_0400.
REQ-033 branch_base_pc 0x100, offset 16'hFFFE with simultaneous ack -> data discarded, next imem_addr = 0xFC; jr and jump asserted together -> jr_target wins.
REQ-034 rst low mid-request with ack following one cycle later -> outputs zero, ack ignored, first post-reset imem_addr = RESET_PC.
REQ-035 IF_ALIGN_CHECK_EN defined, jr_target 0x0000_1002 -> fetch_err = 1 until reset, imem_addr = 0x0000_1000.
